fwd_scoreboard: RTL and testbench
=================================

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have parameter NREG, 32, number of architectural registers; register 0 is hardwired zero.
REQ-002 SHALL have parameter NSRC, 2, number of source operands looked up per cycle (2 or 3).
REQ-003 SHALL have parameter DEPTH, 6, stages from issue to retire; age 1 = EX1, age DEPTH = WB.
REQ-004 SHALL have parameter ALU_RDY, 2, minimum age at which an ALU result is forwardable.
REQ-005 SHALL have parameter LD_RDY, 5, minimum age at which a load result is forwardable.
REQ-006 SHALL have parameter COMMIT_AGE, 3, first age not cancelled by FLUSH.
REQ-007 SHALL use RW = $clog2(NREG) and SW = $clog2(DEPTH+1).
REQ-008 CLK  in  1  clock; all state changes on rising edge.
REQ-009 RST  in  1  synchronous, active-high reset.
REQ-010 ISSUE_VALID  in  1  instruction with destination enters EX1 this cycle.
REQ-011 ISSUE_RD  in  RW  destination register.
REQ-012 ISSUE_TYPE  in  2  00 idle, 01 ALU, 10 load, 11 long-op.
REQ-013 ADVANCE  in  1  pipeline moves this cycle; 0 freezes all ages.
REQ-014 FLUSH  in  1  cancel younger-than-commit entries.
REQ-015 SRC_SEL  in  NSRC*RW  packed source register indices.
REQ-016 FWD_SEL  out  NSRC*SW  per source: 0 = register file, k = forward from stage age k.
REQ-017 SRC_RDY  out  NSRC  per source operand available.
REQ-018 STALL  out  1  high when any SRC_RDY bit is low.

Function
REQ-019 SHALL keep per register 1..NREG-1: valid bit, 2-bit type, SW-bit age.
REQ-020 SHALL accept an issue only when ISSUE_VALID & ADVANCE & !STALL & !FLUSH & ISSUE_RD!=0 & ISSUE_TYPE!=00: entry set valid, type latched, age=1, overwriting any older entry for that register.
REQ-021 On ADVANCE, every other valid entry SHALL increment age; an entry at age DEPTH SHALL become invalid.
REQ-022 With ADVANCE=0, all entries SHALL hold unchanged.
REQ-023 FLUSH SHALL invalidate every entry with age < COMMIT_AGE in the same edge, regardless of ADVANCE; older entries age normally; FLUSH beats a simultaneous issue.
REQ-024 Lookup SHALL be combinational, zero latency: source 0 or invalid entry -> FWD_SEL=0, SRC_RDY=1.
REQ-025 Valid entry -> FWD_SEL=age; SRC_RDY=1 iff (ALU and age>=ALU_RDY) or (load and age>=LD_RDY).
REQ-026 A register issued and read in the same cycle SHALL report the pre-edge state.

Reset
REQ-027 RST SHALL clear all valid bits, ages to 0, types to 00; outputs then FWD_SEL=0, SRC_RDY all 1, STALL=0.
REQ-028 RST mid-operation SHALL override issue, ADVANCE and FLUSH in that cycle.

Configuration
REQ-029 With FWD_SCOREBOARD_LONGOP_EN defined: ports LONGOP_DONE (in, 1) and LONGOP_RD (in, RW) SHALL exist; a type-11 entry SHALL hold at age 1 (SRC_RDY=0) until LONGOP_DONE with matching LONGOP_RD, then jump to age ALU_RDY and age normally; FLUSH SHALL clear it.
REQ-030 Without FWD_SCOREBOARD_LONGOP_EN: ports absent; type 11 treated as idle (no entry created).

Structure
REQ-031 Type encodings and default latencies SHALL live in the shared pipeline parameter package.
REQ-032 One sub-module fwd_scoreboard_entry (single-register valid/type/age state machine) SHALL be instantiated NREG-1 times.

Verification
REQ-033 Issue ALU to x5, read x5 next cycle (age 1) -> SRC_RDY=0, STALL=1; after one ADVANCE -> FWD_SEL=2, SRC_RDY=1.
REQ-034 Issue load to x7, ADVANCE x4 -> SRC_RDY=1 at age 5, FWD_SEL=5; after age 6 + ADVANCE -> FWD_SEL=0.
REQ-035 Entries x3 age 1, x4 age 3, FLUSH=1 -> x3 invalid, x4 age 4.
REQ-036 SRC_SEL=0 with ISSUE_RD=0 issued -> FWD_SEL=0, SRC_RDY=1, no entry.
REQ-037 ADVANCE=0 for 10 cycles with x9 at age 2 -> age stays 2; RST then -> all FWD_SEL=0, STALL=0.
REQ-038 LONGOP_EN: long-op to x10, 8 cycles ADVANCE -> SRC_RDY=0; LONGOP_DONE, LONGOP_RD=10 -> FWD_SEL=2, SRC_RDY=1.

Source files
------------

// File: rtl/fwd_scoreboard_pkg.sv
// Shared pipeline parameters for the forwarding scoreboard: operation type
// encodings and the default stage latencies used by the top and its entries.
package fwd_scoreboard_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_ALU  = 2'b01,
    OP_LOAD = 2'b10,
    OP_LONG = 2'b11
  } op_type_e;

  localparam int DEF_DEPTH      = 6;
  localparam int DEF_ALU_RDY    = 2;
  localparam int DEF_LD_RDY     = 5;
  localparam int DEF_COMMIT_AGE = 3;

  // A type creates a scoreboard entry only if it produces a tracked result;
  // long-ops count only when the long-op completion interface is built in.
  function automatic logic is_issuable(input op_type_e t, input logic longop_en);
    return (t == OP_ALU) || (t == OP_LOAD) || (longop_en && (t == OP_LONG));
  endfunction

endpackage

// File: rtl/fwd_scoreboard_entry.sv
// One register's in-flight result tracker: valid bit, producing op type and
// pipeline age. A pending long-op parks at age 1 until its completion strobe,
// then continues as an ALU result at the ALU-ready age.
module fwd_scoreboard_entry
  import fwd_scoreboard_pkg::*;
#(
  parameter int SW         = 3,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int COMMIT_AGE = DEF_COMMIT_AGE,
  parameter int ALU_RDY    = DEF_ALU_RDY
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          issue,
  input  op_type_e      issue_type,
  input  logic          advance,
  input  logic          flush,
  input  logic          longop_done,
  output logic          valid,
  output op_type_e      etype,
  output logic [SW-1:0] age
);

  logic          valid_n;
  op_type_e      type_n;
  logic [SW-1:0] age_n;

  // State register; reset wipes the entry regardless of any other request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid <= 1'b0;
      etype <= OP_IDLE;
      age   <= '0;
    end else begin
      valid <= valid_n;
      etype <= type_n;
      age   <= age_n;
    end
  end

  // Next state: new issue overwrites, flush kills young entries, long-ops
  // wait for completion, everything else ages and retires past the last stage.
  always_comb begin
    valid_n = valid;
    type_n  = etype;
    age_n   = age;
    if (issue) begin
      valid_n = 1'b1;
      type_n  = issue_type;
      age_n   = SW'(1);
    end else if (valid) begin
      if (flush && (age < SW'(COMMIT_AGE))) begin
        valid_n = 1'b0;
        type_n  = OP_IDLE;
        age_n   = '0;
      end else if (etype == OP_LONG) begin
        if (longop_done) begin
          type_n = OP_ALU;
          age_n  = SW'(ALU_RDY);
        end
      end else if (advance) begin
        if (age == SW'(DEPTH)) begin
          valid_n = 1'b0;
          type_n  = OP_IDLE;
          age_n   = '0;
        end else begin
          age_n = age + SW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight destination registers and tells each
// source operand where to read from (register file or a pipeline stage) and
// whether the value is ready yet.
// Optional feature: define FWD_SCOREBOARD_LONGOP_EN to add the LONGOP_DONE /
// LONGOP_RD completion port for variable-latency long-ops (type 11).
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int NREG       = 32,
  parameter int NSRC       = 2,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ALU_RDY    = DEF_ALU_RDY,
  parameter int LD_RDY     = DEF_LD_RDY,
  parameter int COMMIT_AGE = DEF_COMMIT_AGE,
  localparam int RW        = $clog2(NREG),
  localparam int SW        = $clog2(DEPTH + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ISSUE_VALID,
  input  logic [RW-1:0]        ISSUE_RD,
  input  logic [1:0]           ISSUE_TYPE,
  input  logic                 ADVANCE,
  input  logic                 FLUSH,
  input  logic [NSRC*RW-1:0]   SRC_SEL,
`ifdef FWD_SCOREBOARD_LONGOP_EN
  input  logic                 LONGOP_DONE,
  input  logic [RW-1:0]        LONGOP_RD,
`endif
  output logic [NSRC*SW-1:0]   FWD_SEL,
  output logic [NSRC-1:0]      SRC_RDY,
  output logic                 STALL
);

`ifdef FWD_SCOREBOARD_LONGOP_EN
  localparam logic LONGOP_EN = 1'b1;
  logic          longop_done;
  logic [RW-1:0] longop_rd;
  assign longop_done = LONGOP_DONE;
  assign longop_rd   = LONGOP_RD;
`else
  localparam logic LONGOP_EN = 1'b0;
  logic          longop_done;
  logic [RW-1:0] longop_rd;
  assign longop_done = 1'b0;
  assign longop_rd   = '0;
`endif

  logic          entry_valid [NREG];
  op_type_e      entry_type  [NREG];
  logic [SW-1:0] entry_age   [NREG];
  logic          issue_ok;

  // An issue is taken only when the pipe moves, nothing stalls or flushes,
  // and it actually writes a tracked destination.
  assign issue_ok = ISSUE_VALID && ADVANCE && !STALL && !FLUSH &&
                    (ISSUE_RD != '0) &&
                    is_issuable(op_type_e'(ISSUE_TYPE), LONGOP_EN);

  // Register 0 is hardwired zero and never has an in-flight producer.
  assign entry_valid[0] = 1'b0;
  assign entry_type[0]  = OP_IDLE;
  assign entry_age[0]   = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    fwd_scoreboard_entry #(
      .SW         (SW),
      .DEPTH      (DEPTH),
      .COMMIT_AGE (COMMIT_AGE),
      .ALU_RDY    (ALU_RDY)
    ) u_entry (
      .CLK         (CLK),
      .RST         (RST),
      .issue       (issue_ok && (ISSUE_RD == RW'(r))),
      .issue_type  (op_type_e'(ISSUE_TYPE)),
      .advance     (ADVANCE),
      .flush       (FLUSH),
      .longop_done (longop_done && (longop_rd == RW'(r))),
      .valid       (entry_valid[r]),
      .etype       (entry_type[r]),
      .age         (entry_age[r])
    );
  end

  // Zero-latency lookup of every source against the current (pre-edge) state.
  always_comb begin
    FWD_SEL = '0;
    SRC_RDY = '1;
    for (int s = 0; s < NSRC; s++) begin
      if ((int'(SRC_SEL[s*RW +: RW]) < NREG) && entry_valid[SRC_SEL[s*RW +: RW]]) begin
        FWD_SEL[s*SW +: SW] = entry_age[SRC_SEL[s*RW +: RW]];
        SRC_RDY[s] =
          ((entry_type[SRC_SEL[s*RW +: RW]] == OP_ALU) &&
           (entry_age[SRC_SEL[s*RW +: RW]] >= SW'(ALU_RDY))) ||
          ((entry_type[SRC_SEL[s*RW +: RW]] == OP_LOAD) &&
           (entry_age[SRC_SEL[s*RW +: RW]] >= SW'(LD_RDY)));
      end
    end
  end

  assign STALL = ~(&SRC_RDY);

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios with hand-derived
// expectations, then randomized traffic compared against a per-register
// behavioural model of in-flight results.
module tb_fwd_scoreboard;

  localparam int NREG       = 32;
  localparam int NSRC       = 2;
  localparam int DEPTH      = 6;
  localparam int ALU_RDY    = 2;
  localparam int LD_RDY     = 5;
  localparam int COMMIT_AGE = 3;
  localparam int RW         = 5;
  localparam int SW         = 3;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 ISSUE_VALID;
  logic [RW-1:0]        ISSUE_RD;
  logic [1:0]           ISSUE_TYPE;
  logic                 ADVANCE;
  logic                 FLUSH;
  logic [NSRC*RW-1:0]   SRC_SEL;
  logic [NSRC*SW-1:0]   FWD_SEL;
  logic [NSRC-1:0]      SRC_RDY;
  logic                 STALL;
`ifdef FWD_SCOREBOARD_LONGOP_EN
  logic                 LONGOP_DONE;
  logic [RW-1:0]        LONGOP_RD;
  bit                   pend_done = 1'b0;
  int                   pend_rd   = 0;
`endif

  int error_count = 0;
  int check_count = 0;

  // Model: whether a register has a result in flight, what produced it and
  // how many pipeline advances it has seen since issue (1 = EX1).
  bit m_valid [NREG];
  int m_type  [NREG];
  int m_age   [NREG];

  fwd_scoreboard #(
    .NREG(NREG), .NSRC(NSRC), .DEPTH(DEPTH), .ALU_RDY(ALU_RDY),
    .LD_RDY(LD_RDY), .COMMIT_AGE(COMMIT_AGE)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ISSUE_VALID (ISSUE_VALID),
    .ISSUE_RD    (ISSUE_RD),
    .ISSUE_TYPE  (ISSUE_TYPE),
    .ADVANCE     (ADVANCE),
    .FLUSH       (FLUSH),
    .SRC_SEL     (SRC_SEL),
`ifdef FWD_SCOREBOARD_LONGOP_EN
    .LONGOP_DONE (LONGOP_DONE),
    .LONGOP_RD   (LONGOP_RD),
`endif
    .FWD_SEL     (FWD_SEL),
    .SRC_RDY     (SRC_RDY),
    .STALL       (STALL)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_lookup(input logic [NSRC*RW-1:0] sel,
                                       output logic [NSRC*SW-1:0] fwd,
                                       output logic [NSRC-1:0] rdy);
    fwd = '0;
    rdy = '1;
    for (int s = 0; s < NSRC; s++) begin
      int r = int'(sel[s*RW +: RW]);
      if (r != 0 && m_valid[r]) begin
        fwd[s*SW +: SW] = SW'(m_age[r]);
        case (m_type[r])
          1:       rdy[s] = (m_age[r] >= ALU_RDY);
          2:       rdy[s] = (m_age[r] >= LD_RDY);
          default: rdy[s] = 1'b0;
        endcase
      end
    end
  endfunction

  task automatic compareModel(input string where);
    logic [NSRC*SW-1:0] ef;
    logic [NSRC-1:0]    er;
    model_lookup(SRC_SEL, ef, er);
    checkOutput({where, "_fwd"}, 64'(FWD_SEL), 64'(ef));
    checkOutput({where, "_rdy"}, 64'(SRC_RDY), 64'(er));
    checkOutput({where, "_stall"}, 64'(STALL), 64'(!(&er)));
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    if (RST) begin
      for (int r = 0; r < NREG; r++) begin
        m_valid[r] = 1'b0; m_type[r] = 0; m_age[r] = 0;
      end
    end else begin
      logic [NSRC*SW-1:0] ef;
      logic [NSRC-1:0]    er;
      bit type_ok;
      bit accept;
      model_lookup(SRC_SEL, ef, er);
      type_ok = (ISSUE_TYPE == 2'd1) || (ISSUE_TYPE == 2'd2);
`ifdef FWD_SCOREBOARD_LONGOP_EN
      type_ok = type_ok || (ISSUE_TYPE == 2'd3);
`endif
      accept = ISSUE_VALID && ADVANCE && (&er) && !FLUSH && (ISSUE_RD != 0) && type_ok;
      for (int r = 1; r < NREG; r++) begin
        if (accept && int'(ISSUE_RD) == r) begin
          m_valid[r] = 1'b1; m_type[r] = int'(ISSUE_TYPE); m_age[r] = 1;
        end else if (m_valid[r]) begin
          if (FLUSH && m_age[r] < COMMIT_AGE) begin
            m_valid[r] = 1'b0; m_type[r] = 0; m_age[r] = 0;
          end else if (m_type[r] == 3) begin
`ifdef FWD_SCOREBOARD_LONGOP_EN
            if (LONGOP_DONE && int'(LONGOP_RD) == r) begin
              m_type[r] = 1; m_age[r] = ALU_RDY;
            end
`endif
          end else if (ADVANCE) begin
            if (m_age[r] == DEPTH) begin
              m_valid[r] = 1'b0; m_type[r] = 0; m_age[r] = 0;
            end else begin
              m_age[r] = m_age[r] + 1;
            end
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit iv, input int rd, input int typ,
                               input bit adv, input bit fl, input logic [NSRC*RW-1:0] sel);
    @(negedge CLK);
    RST = rst; ISSUE_VALID = iv; ISSUE_RD = RW'(rd); ISSUE_TYPE = 2'(typ);
    ADVANCE = adv; FLUSH = fl; SRC_SEL = sel;
`ifdef FWD_SCOREBOARD_LONGOP_EN
    LONGOP_DONE = pend_done; LONGOP_RD = RW'(pend_rd); pend_done = 1'b0;
`endif
    #1;
    compareModel("cyc");
    @(posedge CLK);
    modelStep();
  endtask

  // Read one register on source 0 with the pipe frozen and check it directly.
  task automatic probe(input string tag, input int rd, input int exp_fwd, input bit exp_rdy);
    @(negedge CLK);
    RST = 1'b0; ISSUE_VALID = 1'b0; ISSUE_RD = '0; ISSUE_TYPE = 2'd0;
    ADVANCE = 1'b0; FLUSH = 1'b0; SRC_SEL = '0; SRC_SEL[RW-1:0] = RW'(rd);
`ifdef FWD_SCOREBOARD_LONGOP_EN
    LONGOP_DONE = 1'b0;
`endif
    #1;
    checkOutput({tag, "_fwd0"}, 64'(FWD_SEL[SW-1:0]), 64'(exp_fwd));
    checkOutput({tag, "_rdy0"}, 64'(SRC_RDY[0]), 64'(exp_rdy));
    checkOutput({tag, "_stl"}, 64'(STALL), 64'(!exp_rdy));
    compareModel(tag);
    @(posedge CLK);
    modelStep();
  endtask

  task automatic issueOp(input int rd, input int typ);
    applyStimulus(1'b0, 1'b1, rd, typ, 1'b1, 1'b0, '0);
  endtask

  task automatic advanceOnly();
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, '0);
  endtask

  task automatic resetCycle();
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    RST = 1'b1; ISSUE_VALID = 1'b0; ISSUE_RD = '0; ISSUE_TYPE = 2'd0;
    ADVANCE = 1'b0; FLUSH = 1'b0; SRC_SEL = '0;
`ifdef FWD_SCOREBOARD_LONGOP_EN
    LONGOP_DONE = 1'b0; LONGOP_RD = '0;
`endif
    repeat (2) @(posedge CLK);
    modelStep();

    // Reset state.
    probe("rst", 1, 0, 1'b1);
    @(negedge CLK); #1;
    checkOutput("rst_fwd_all", 64'(FWD_SEL), 64'd0);
    checkOutput("rst_rdy_all", 64'(SRC_RDY), 64'd3);

    // ALU result: not ready in EX1, forwardable one stage later.
    issueOp(5, 1);
    probe("alu_age1", 5, 1, 1'b0);
    advanceOnly();
    probe("alu_age2", 5, 2, 1'b1);

    // Load result: ready only from age 5, retires after WB.
    resetCycle();
    issueOp(7, 2);
    repeat (3) advanceOnly();
    probe("ld_age4", 7, 4, 1'b0);
    advanceOnly();
    probe("ld_age5", 7, 5, 1'b1);
    advanceOnly();
    probe("ld_age6", 7, 6, 1'b1);
    advanceOnly();
    probe("ld_retired", 7, 0, 1'b1);

    // Flush kills young entries, older ones age on; flush beats a new issue.
    resetCycle();
    issueOp(4, 1);
    advanceOnly();
    issueOp(3, 2);
    applyStimulus(1'b0, 1'b1, 8, 1, 1'b1, 1'b1, '0);
    probe("fl_x3", 3, 0, 1'b1);
    probe("fl_x4", 4, 4, 1'b1);
    probe("fl_x8", 8, 0, 1'b1);
    issueOp(3, 1);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, '0);
    probe("flhold_x3", 3, 0, 1'b1);
    probe("flhold_x4", 4, 5, 1'b1);

    // Non-tracked issues create no entry.
    issueOp(0, 1);
    probe("rd0", 0, 0, 1'b1);
    issueOp(6, 0);
    probe("idle_type", 6, 0, 1'b1);
`ifndef FWD_SCOREBOARD_LONGOP_EN
    issueOp(11, 3);
    probe("long_as_idle", 11, 0, 1'b1);
`endif

    // A stalled cycle must not accept an issue, but the pipe still ages.
    resetCycle();
    issueOp(5, 1);
    applyStimulus(1'b0, 1'b1, 6, 1, 1'b1, 1'b0, {RW'(0), RW'(5)});
    probe("stall_x6", 6, 0, 1'b1);
    probe("stall_x5", 5, 2, 1'b1);

    // Frozen pipe holds ages; reset overrides a simultaneous issue.
    resetCycle();
    issueOp(9, 1);
    advanceOnly();
    repeat (10) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, '0);
    probe("hold_x9", 9, 2, 1'b1);
    applyStimulus(1'b1, 1'b1, 12, 1, 1'b1, 1'b1, '0);
    probe("rst_x9", 9, 0, 1'b1);
    probe("rst_x12", 12, 0, 1'b1);

`ifdef FWD_SCOREBOARD_LONGOP_EN
    // Long-op parks at age 1 until its completion strobe.
    issueOp(10, 3);
    repeat (8) advanceOnly();
    probe("long_wait", 10, 1, 1'b0);
    pend_done = 1'b1; pend_rd = 10;
    advanceOnly();
    probe("long_done", 10, 2, 1'b1);
`endif

    // Randomized traffic concentrated on a few registers to force hits.
    for (int i = 0; i < 400; i++) begin
      logic [NSRC*RW-1:0] sel;
      for (int s = 0; s < NSRC; s++) sel[s*RW +: RW] = RW'($urandom_range(0, 7));
`ifdef FWD_SCOREBOARD_LONGOP_EN
      pend_done = ($urandom_range(0, 3) == 0);
      pend_rd   = $urandom_range(0, 7);
`endif
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 7), $urandom_range(0, 3),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, sel);
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
